// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency sync FIFO into a valid/ready stream with a burst-boundary last flag.
// A 3-entry skid buffer covers the read latency so fifo_rd_en never depends on m_ready.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  // state | meaning
  // IDLE  | nothing requested, reads start the cycle enable rises
  // RUN   | streaming, reads issued whenever there is room
  // FLUSH | enable dropped, delivering buffered / in-flight words only

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [WIDTH-1:0]  buf_q [3];
  logic [WIDTH-1:0]  buf_d [3];
  logic              push, pop, room;

  function automatic logic [1:0] adv(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf_q[rd_ptr_q];
  assign m_last     = m_valid && (beat_q == BEAT_LAST);
  assign word_count = word_count_q;
  assign busy       = m_valid || inflight_q;

  // Room counts the in-flight word too, so a captured word always has a slot.
  assign room       = ((occ_q + {1'b0, inflight_q}) != 2'd3);
  assign fifo_rd_en = enable && !fifo_empty && room && !reset;

  always_comb begin
    push         = inflight_q;
    pop          = m_valid && m_ready;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    beat_d       = beat_q;
    word_count_d = word_count_q;
    inflight_d   = fifo_rd_en;
    state_d      = state_q;

    if (push) begin
      buf_d[wr_ptr_q] = fifo_data;
      wr_ptr_d        = adv(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d     = adv(rd_ptr_q);
      beat_d       = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
      word_count_d = word_count_q + CNT_W'(1);
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = busy ? S_FLUSH : S_IDLE;
      S_FLUSH: begin
        if (enable)     state_d = S_RUN;
        else if (!busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      inflight_q   <= 1'b0;
      beat_q       <= '0;
      word_count_q <= '0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      inflight_q   <= inflight_d;
      beat_q       <= beat_d;
      word_count_q <= word_count_d;
      buf_q        <= buf_d;
    end
  end

endmodule
